// File: rtl/jelly_python_sync_decoder_if.sv
// Interfaces for the PYTHON300 sync decoder: deserialized kernel input and AXI4-Stream pixel output.

interface jelly_python_kernel_if #(
  parameter int CHANNELS  = 4,
  parameter int DATA_BITS = 10
);
  logic [CHANNELS*DATA_BITS-1:0] s_data;
  logic [DATA_BITS-1:0]          s_sync;
  logic                          s_valid;

  modport master (output s_data, output s_sync, output s_valid);
  modport slave  (input  s_data, input  s_sync, input  s_valid);
endinterface

interface jelly_python_axi4s_if #(
  parameter int CHANNELS  = 4,
  parameter int DATA_BITS = 10
);
  logic                          m_axi4s_tuser;
  logic                          m_axi4s_tlast;
  logic [CHANNELS*DATA_BITS-1:0] m_axi4s_tdata;
  logic                          m_axi4s_tvalid;
  logic                          m_axi4s_tready;

  modport master (output m_axi4s_tuser, output m_axi4s_tlast, output m_axi4s_tdata,
                  output m_axi4s_tvalid, input m_axi4s_tready);
  modport slave  (input  m_axi4s_tuser, input  m_axi4s_tlast, input  m_axi4s_tdata,
                  input  m_axi4s_tvalid, output m_axi4s_tready);
endinterface

// File: rtl/jelly_python_sync_decoder.sv
// PYTHON300 sync-channel decoder: strips training/blank/black/CRC words and
// emits image kernels as AXI4-Stream with tuser (frame start) and tlast (line end).

module jelly_python_sync_decoder #(
  parameter int                   CHANNELS  = 4,
  parameter int                   DATA_BITS = 10,
  parameter logic [DATA_BITS-1:0] CODE_FS   = 10'h2aa,
  parameter logic [DATA_BITS-1:0] CODE_LS   = 10'h0aa,
  parameter logic [DATA_BITS-1:0] CODE_LE   = 10'h12a,
  parameter logic [DATA_BITS-1:0] CODE_FE   = 10'h3aa,
  parameter logic [DATA_BITS-1:0] CODE_BL   = 10'h22a,
  parameter logic [DATA_BITS-1:0] CODE_IMG  = 10'h035,
  parameter logic [DATA_BITS-1:0] CODE_CRC  = 10'h059,
  parameter logic [DATA_BITS-1:0] CODE_TR   = 10'h3a6
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 enable,
  jelly_python_kernel_if.slave s_kernel,
  jelly_python_axi4s_if.master m_axi4s,
  output logic                 busy,
  output logic                 sync_error,
  output logic                 overflow,
  output logic [15:0]          frame_count
);

  localparam int W = CHANNELS * DATA_BITS;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LWAIT, ST_LID, ST_LDATA, ST_EID, ST_CRC, ST_BSKIP, ST_BID
  } state_t;

  state_t         state_q, state_d;
  logic           fe_pending_q, fe_pending_d;
  logic [15:0]    frame_count_q, frame_count_d;
  logic           busy_q, busy_d;
  logic           sync_error_q, sync_error_d;
  logic           overflow_q, overflow_d;
  logic           tvalid_q, tvalid_d;
  logic           tuser_q, tuser_d;
  logic           tlast_q, tlast_d;
  logic [W-1:0]   tdata_q, tdata_d;

  logic           pix;
  logic           pix_user;
  logic           pix_last;
  logic [DATA_BITS-1:0] code;

  assign code = s_kernel.s_sync;

  always_comb begin
    state_d       = state_q;
    fe_pending_d  = fe_pending_q;
    frame_count_d = frame_count_q;
    sync_error_d  = 1'b0;
    overflow_d    = 1'b0;
    tvalid_d      = tvalid_q;
    tuser_d       = tuser_q;
    tlast_d       = tlast_q;
    tdata_d       = tdata_q;
    pix           = 1'b0;
    pix_user      = 1'b0;
    pix_last      = 1'b0;

    if (s_kernel.s_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (code == CODE_FS && enable) begin
            pix      = 1'b1;
            pix_user = 1'b1;
            state_d  = ST_LID;
          end
        end
        ST_LWAIT: begin
          if (code == CODE_LS) begin
            pix     = 1'b1;
            state_d = ST_LID;
          end else if (code == CODE_BL) begin
            state_d = ST_BSKIP;
          end else if (code == CODE_FS) begin
            // Unexpected frame start: flag it, then restart as a fresh frame if allowed.
            sync_error_d = 1'b1;
            if (enable) begin
              pix      = 1'b1;
              pix_user = 1'b1;
              state_d  = ST_LID;
            end
          end else if (code != CODE_TR && code != CODE_CRC) begin
            sync_error_d = 1'b1;
          end
        end
        ST_LID: begin
          pix     = 1'b1;
          state_d = ST_LDATA;
        end
        ST_LDATA: begin
          if (code == CODE_IMG) begin
            pix = 1'b1;
          end else if (code == CODE_LE || code == CODE_FE) begin
            pix          = 1'b1;
            fe_pending_d = (code == CODE_FE);
            state_d      = ST_EID;
          end else begin
            sync_error_d = 1'b1;
            state_d      = ST_LWAIT;
          end
        end
        ST_EID: begin
          pix      = 1'b1;
          pix_last = 1'b1;
          state_d  = ST_CRC;
        end
        ST_CRC: begin
          if (fe_pending_q) begin
            frame_count_d = frame_count_q + 16'd1;
            state_d       = ST_IDLE;
          end else begin
            state_d = ST_LWAIT;
          end
        end
        ST_BSKIP: begin
          if (code == CODE_LE || code == CODE_FE) begin
            fe_pending_d = (code == CODE_FE);
            state_d      = ST_BID;
          end
        end
        ST_BID:  state_d = ST_CRC;
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);

    // Single output register: a word that cannot be loaded is dropped, but its framing flags survive.
    if (pix) begin
      if (!tvalid_q || m_axi4s.m_axi4s_tready) begin
        tvalid_d = 1'b1;
        tdata_d  = s_kernel.s_data;
        tuser_d  = pix_user;
        tlast_d  = pix_last;
      end else begin
        overflow_d = 1'b1;
        tuser_d    = tuser_q | pix_user;
        tlast_d    = tlast_q | pix_last;
      end
    end else if (m_axi4s.m_axi4s_tready) begin
      tvalid_d = 1'b0;
      tuser_d  = 1'b0;
      tlast_d  = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= ST_IDLE;
      fe_pending_q  <= 1'b0;
      frame_count_q <= 16'd0;
      busy_q        <= 1'b0;
      sync_error_q  <= 1'b0;
      overflow_q    <= 1'b0;
      tvalid_q      <= 1'b0;
      tuser_q       <= 1'b0;
      tlast_q       <= 1'b0;
      tdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      fe_pending_q  <= fe_pending_d;
      frame_count_q <= frame_count_d;
      busy_q        <= busy_d;
      sync_error_q  <= sync_error_d;
      overflow_q    <= overflow_d;
      tvalid_q      <= tvalid_d;
      tuser_q       <= tuser_d;
      tlast_q       <= tlast_d;
      tdata_q       <= tdata_d;
    end
  end

  assign m_axi4s.m_axi4s_tvalid = tvalid_q;
  assign m_axi4s.m_axi4s_tuser  = tuser_q;
  assign m_axi4s.m_axi4s_tlast  = tlast_q;
  assign m_axi4s.m_axi4s_tdata  = tdata_q;
  assign busy                   = busy_q;
  assign sync_error             = sync_error_q;
  assign overflow               = overflow_q;
  assign frame_count            = frame_count_q;

endmodule

// File: tb/tb_jelly_python_sync_decoder.sv
// Directed bench for jelly_python_sync_decoder: scoreboarded pixel stream plus
// framing/overflow/sync-error statistics over several sensor frame scenarios.

module tb_jelly_python_sync_decoder;

  localparam int CH = 4;
  localparam int DB = 10;
  localparam int W  = CH * DB;

  localparam logic [9:0] C_FS  = 10'h2aa;
  localparam logic [9:0] C_LS  = 10'h0aa;
  localparam logic [9:0] C_LE  = 10'h12a;
  localparam logic [9:0] C_FE  = 10'h3aa;
  localparam logic [9:0] C_BL  = 10'h22a;
  localparam logic [9:0] C_IMG = 10'h035;
  localparam logic [9:0] C_CRC = 10'h059;
  localparam logic [9:0] C_TR  = 10'h3a6;
  localparam logic [9:0] C_ID  = 10'h015;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        enable;
  logic        busy;
  logic        sync_error;
  logic        overflow;
  logic [15:0] frame_count;

  jelly_python_kernel_if #(.CHANNELS(CH), .DATA_BITS(DB)) kif ();
  jelly_python_axi4s_if  #(.CHANNELS(CH), .DATA_BITS(DB)) aif ();

  jelly_python_sync_decoder #(.CHANNELS(CH), .DATA_BITS(DB)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .enable      (enable),
    .s_kernel    (kif),
    .m_axi4s     (aif),
    .busy        (busy),
    .sync_error  (sync_error),
    .overflow    (overflow),
    .frame_count (frame_count)
  );

  always #5 aclk = ~aclk;

  int checks    = 0;
  int failures  = 0;
  int out_cnt   = 0;
  int tuser_cnt = 0;
  int tlast_cnt = 0;
  int ovf_cnt   = 0;
  int serr_cnt  = 0;
  int pix_sent  = 0;
  int px        = 0;
  int exp_fc    = 0;
  bit sb_en     = 1'b1;
  bit gap_en    = 1'b0;
  bit toggle_en = 1'b0;
  logic [41:0] sb_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
    checks++;
    assert (got === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp_v);
    end
  endtask

  function automatic logic [W-1:0] pat(input int p);
    logic [W-1:0] d;
    for (int i = 0; i < CH; i++) d[i*DB +: DB] = 10'(p + i);
    return d;
  endfunction

  // Output monitor: sampled on the falling edge, away from the active edge.
  always @(negedge aclk) begin
    logic [41:0] exp_w;
    if (aresetn) begin
      if (aif.m_axi4s_tvalid && aif.m_axi4s_tready) begin
        out_cnt++;
        tuser_cnt += int'(aif.m_axi4s_tuser);
        tlast_cnt += int'(aif.m_axi4s_tlast);
        if (sb_en) begin
          chk("sb_word_expected", 64'(sb_q.size() != 0), 64'd1);
          if (sb_q.size() != 0) begin
            exp_w = sb_q.pop_front();
            chk("sb_word", {aif.m_axi4s_tuser, aif.m_axi4s_tlast, aif.m_axi4s_tdata}, 64'(exp_w));
          end
        end
      end
      if (sync_error) serr_cnt++;
      if (overflow)   ovf_cnt++;
    end
  end

  initial begin
    aif.m_axi4s_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      if (toggle_en) aif.m_axi4s_tready = ~aif.m_axi4s_tready;
      else           aif.m_axi4s_tready = 1'b1;
    end
  end

  task automatic send(input logic [9:0] sync, input bit is_pix, input bit u, input bit l);
    logic [63:0] r;
    if (gap_en && $urandom_range(0, 2) == 0) begin
      r = {$urandom, $urandom};
      kif.s_valid = 1'b0;
      kif.s_sync  = C_FS;
      kif.s_data  = r[W-1:0];
      repeat ($urandom_range(1, 2)) begin
        @(posedge aclk);
        #1;
      end
    end
    kif.s_valid = 1'b1;
    kif.s_sync  = sync;
    if (is_pix) begin
      kif.s_data = pat(px);
      if (sb_en) sb_q.push_back({u, l, pat(px)});
      px += 4;
      pix_sent++;
    end else begin
      r = {$urandom, $urandom};
      kif.s_data = r[W-1:0];
    end
    @(posedge aclk);
    #1;
    kif.s_valid = 1'b0;
  endtask

  // One sensor line: start, ID, 156 image words, end, ID (tlast), CRC.
  task automatic line(input logic [9:0] sc, input logic [9:0] ec, input bit o, input bit first);
    if (first && o) px = 0;
    send(sc, o, first, 1'b0);
    send(C_ID, o, 1'b0, 1'b0);
    repeat (156) send(C_IMG, o, 1'b0, 1'b0);
    send(ec, o, 1'b0, 1'b0);
    send(C_ID, o, 1'b0, 1'b1);
    send(C_CRC, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    kif.s_valid = 1'b0;
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || aif.m_axi4s_tvalid) && n < 2000) begin
      @(posedge aclk);
      #1;
      n++;
    end
    chk("drain_bound", 64'(n < 2000), 64'd1);
  endtask

  task automatic clr();
    out_cnt = 0; tuser_cnt = 0; tlast_cnt = 0; ovf_cnt = 0; serr_cnt = 0; pix_sent = 0;
  endtask

  initial begin
    aresetn     = 1'b0;
    enable      = 1'b0;
    kif.s_valid = 1'b0;
    kif.s_sync  = C_TR;
    kif.s_data  = '0;
    @(posedge aclk);
    #1;
    chk("reset_outputs", {aif.m_axi4s_tvalid, aif.m_axi4s_tuser, aif.m_axi4s_tlast,
        aif.m_axi4s_tdata, busy, sync_error, overflow, frame_count}, 64'd0);
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    enable  = 1'b1;

    // 1: training, black line before FS, 64-line frame with in-frame black line.
    clr();
    repeat (20) send(C_TR, 1'b0, 1'b0, 1'b0);
    line(C_BL, C_LE, 1'b0, 1'b0);
    line(C_FS, C_LE, 1'b1, 1'b1);
    line(C_BL, C_LE, 1'b0, 1'b0);
    for (int i = 1; i < 64; i++) line(C_LS, (i == 63) ? C_FE : C_LE, 1'b1, 1'b0);
    exp_fc++;
    drain();
    chk("main_words", 64'(out_cnt), 64'd10240);
    chk("main_tuser", 64'(tuser_cnt), 64'd1);
    chk("main_tlast", 64'(tlast_cnt), 64'd64);
    chk("main_frame_count", 64'(frame_count), 64'(exp_fc));
    chk("main_sync_error", 64'(serr_cnt), 64'd0);
    chk("main_overflow", 64'(ovf_cnt), 64'd0);
    chk("main_busy", 64'(busy), 64'd0);
    $display("step main_frame words=%0d tlast=%0d frame_count=%0d", out_cnt, tlast_cnt, frame_count);

    // 2: tready toggling; content is unpredictable, framing and word accounting are not.
    clr();
    sb_en     = 1'b0;
    toggle_en = 1'b1;
    line(C_FS, C_LE, 1'b1, 1'b1);
    line(C_LS, C_LE, 1'b1, 1'b0);
    line(C_LS, C_LE, 1'b1, 1'b0);
    line(C_LS, C_FE, 1'b1, 1'b0);
    exp_fc++;
    toggle_en = 1'b0;
    idle(2);
    drain();
    sb_en = 1'b1;
    chk("toggle_tuser", 64'(tuser_cnt), 64'd1);
    chk("toggle_tlast", 64'(tlast_cnt), 64'd4);
    chk("toggle_overflow_seen", 64'(ovf_cnt > 0), 64'd1);
    chk("toggle_accounting", 64'(out_cnt + ovf_cnt), 64'(pix_sent));
    chk("toggle_frame_count", 64'(frame_count), 64'(exp_fc));
    $display("step tready_toggle accepted=%0d dropped=%0d sent=%0d", out_cnt, ovf_cnt, pix_sent);

    // 3: training code inside LDATA after 10 words aborts the line.
    clr();
    line(C_FS, C_LE, 1'b1, 1'b1);
    send(C_LS, 1'b1, 1'b0, 1'b0);
    send(C_ID, 1'b1, 1'b0, 1'b0);
    repeat (8) send(C_IMG, 1'b1, 1'b0, 1'b0);
    send(C_TR, 1'b0, 1'b0, 1'b0);
    line(C_LS, C_FE, 1'b1, 1'b0);
    exp_fc++;
    drain();
    chk("err_sync_error", 64'(serr_cnt), 64'd1);
    chk("err_tlast", 64'(tlast_cnt), 64'd2);
    chk("err_words", 64'(out_cnt), 64'd330);
    chk("err_frame_count", 64'(frame_count), 64'(exp_fc));
    $display("step sync_error words=%0d sync_errors=%0d", out_cnt, serr_cnt);

    // 4: enable dropped mid-frame; frame completes, later FS ignored.
    clr();
    line(C_FS, C_LE, 1'b1, 1'b1);
    enable = 1'b0;
    line(C_LS, C_LE, 1'b1, 1'b0);
    chk("en_busy_mid", 64'(busy), 64'd1);
    line(C_LS, C_FE, 1'b1, 1'b0);
    exp_fc++;
    chk("en_busy_fall", 64'(busy), 64'd0);
    chk("en_frame_count", 64'(frame_count), 64'(exp_fc));
    drain();
    chk("en_words", 64'(out_cnt), 64'd480);
    line(C_FS, C_LE, 1'b0, 1'b0);
    idle(3);
    chk("en_no_output", 64'(out_cnt), 64'd480);
    chk("en_busy_idle", 64'(busy), 64'd0);
    enable = 1'b1;
    $display("step enable_off words=%0d frame_count=%0d", out_cnt, frame_count);

    // 5: asynchronous reset in the middle of line 5 while a word is held.
    clr();
    line(C_FS, C_LE, 1'b1, 1'b1);
    repeat (3) line(C_LS, C_LE, 1'b1, 1'b0);
    send(C_LS, 1'b1, 1'b0, 1'b0);
    send(C_ID, 1'b1, 1'b0, 1'b0);
    repeat (20) send(C_IMG, 1'b1, 1'b0, 1'b0);
    #2;
    aresetn = 1'b0;
    #1;
    chk("rst_outputs", {aif.m_axi4s_tvalid, aif.m_axi4s_tuser, aif.m_axi4s_tlast,
        aif.m_axi4s_tdata, busy, sync_error, overflow, frame_count}, 64'd0);
    sb_q.delete();
    exp_fc = 0;
    @(posedge aclk);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    clr();
    line(C_LS, C_LE, 1'b0, 1'b0);
    chk("rst_idle_busy", 64'(busy), 64'd0);
    line(C_FS, C_LE, 1'b1, 1'b1);
    line(C_LS, C_FE, 1'b1, 1'b0);
    exp_fc++;
    drain();
    chk("rst_tuser", 64'(tuser_cnt), 64'd1);
    chk("rst_tlast", 64'(tlast_cnt), 64'd2);
    chk("rst_frame_count", 64'(frame_count), 64'(exp_fc));
    $display("step reset_mid_line words=%0d frame_count=%0d", out_cnt, frame_count);

    // 6: random s_valid gaps; scoreboard content must match the continuous case.
    clr();
    gap_en = 1'b1;
    line(C_FS, C_LE, 1'b1, 1'b1);
    line(C_BL, C_LE, 1'b0, 1'b0);
    line(C_LS, C_LE, 1'b1, 1'b0);
    line(C_LS, C_LE, 1'b1, 1'b0);
    line(C_LS, C_FE, 1'b1, 1'b0);
    exp_fc++;
    gap_en = 1'b0;
    drain();
    chk("gap_words", 64'(out_cnt), 64'd640);
    chk("gap_tlast", 64'(tlast_cnt), 64'd4);
    chk("gap_tuser", 64'(tuser_cnt), 64'd1);
    chk("gap_frame_count", 64'(frame_count), 64'(exp_fc));
    $display("step valid_gaps words=%0d frame_count=%0d", out_cnt, frame_count);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
